// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory responder and the sequencer.
//   - Responder state encoding (debug output rstate).
//   - Default data/address widths.
//   - Opcode constants decoded by the sequencer.
package cpu_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_AWIDTH = 5;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'b00,
        RS_READ  = 2'b01,
        RS_WRITE = 2'b10,
        RS_FAULT = 2'b11
    } rstate_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

endpackage

// File: rtl/mem_responder_if.sv
// Memory strobe bus between the CPU sequencer (master) and the memory
// responder (slave).
//   master drives: addr, mem_rd, mem_wr, data_in
//   slave drives : data_out, rd_valid, wr_done, err, rd_count, wr_count, rstate
interface mem_responder_if #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 5,
    parameter int CNTW   = 8
);
    logic [AWIDTH-1:0] addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              rd_valid;
    logic              wr_done;
    logic              err;
    logic [CNTW-1:0]   rd_count;
    logic [CNTW-1:0]   wr_count;
    logic [1:0]        rstate;

    modport master (
        output addr, mem_rd, mem_wr, data_in,
        input  data_out, rd_valid, wr_done, err, rd_count, wr_count, rstate
    );

    modport slave (
        input  addr, mem_rd, mem_wr, data_in,
        output data_out, rd_valid, wr_done, err, rd_count, wr_count, rstate
    );
endinterface

// File: rtl/mem_responder_sat_counter.sv
// Saturating up-counter used for the responder's debug access counts.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-low
//   inc   : increment request for this cycle
//   count : current value, holds at all-ones
module sat_counter #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [CNTW-1:0] count
);
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU sequencer's mem_rd/mem_wr strobes.
// Holds a DEPTH x WIDTH RAM with registered (1-cycle) read data, commits
// writes on the rising edge of mem_wr only, flags simultaneous strobes as a
// sticky error and keeps saturating read/write counters for debug.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : slave side of mem_responder_if (addr, strobes, data, status)
module mem_responder
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DEPTH  = 32,
    parameter int CNTW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    logic [WIDTH-1:0] ram [DEPTH];

    rstate_e          rstate_q,   rstate_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_done_q,  wr_done_d;
    logic             err_q,      err_d;
    logic             wr_prev_q,  wr_prev_d;

    logic both;
    logic rd_acc;
    logic wr_commit;

    always_comb begin
        both      = bus.mem_rd & bus.mem_wr;
        rd_acc    = bus.mem_rd & ~bus.mem_wr;
        // Only the first cycle of a held mem_wr commits.
        wr_commit = bus.mem_wr & ~bus.mem_rd & ~wr_prev_q;

        rstate_d   = RS_IDLE;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        wr_done_d  = wr_commit;
        err_d      = err_q | both;
        wr_prev_d  = bus.mem_wr;

        if (both) begin
            rstate_d = RS_FAULT;
        end else if (rd_acc) begin
            data_out_d = ram[bus.addr];
            rd_valid_d = 1'b1;
            rstate_d   = RS_READ;
        end else if (wr_commit) begin
            rstate_d = RS_WRITE;
        end
    end

    // The RAM write lives in the non-reset branch so a clock edge while rst
    // is low can never update memory; the array itself is never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate_q   <= RS_IDLE;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
            wr_prev_q  <= 1'b0;
        end else begin
            rstate_q   <= rstate_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
            wr_prev_q  <= wr_prev_d;
            if (wr_commit) begin
                ram[bus.addr] <= bus.data_in;
            end
        end
    end

    sat_counter #(.CNTW(CNTW)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rd_acc),
        .count (bus.rd_count)
    );

    sat_counter #(.CNTW(CNTW)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_commit),
        .count (bus.wr_count)
    );

    assign bus.rstate   = rstate_q;
    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a directed vector table, hand-written
// multi-cycle sequences and a randomized phase checked against a
// behavioural memory model. Two instances run in lockstep, CNTW=8 and CNTW=4.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(8), .AWIDTH(5), .CNTW(8)) ifa ();
    mem_responder_if #(.WIDTH(8), .AWIDTH(5), .CNTW(4)) ifb ();

    mem_responder #(.WIDTH(8), .AWIDTH(5), .DEPTH(32), .CNTW(8)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    mem_responder #(.WIDTH(8), .AWIDTH(5), .DEPTH(32), .CNTW(4)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    int total = 0;
    int bad   = 0;

    // current stimulus
    logic       cur_rd, cur_wr;
    logic [4:0] cur_a;
    logic [7:0] cur_d;

    // behavioural model
    logic [7:0] mem   [32];
    bit         mknow [32];
    bit         m_prev, m_err, m_rv, m_wd, m_dknown;
    logic [1:0] m_st;
    logic [7:0] m_data;
    int         m_rc, m_wc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [4:0] a, input logic [7:0] d);
        cur_rd = rd; cur_wr = wr; cur_a = a; cur_d = d;
        ifa.mem_rd = rd; ifa.mem_wr = wr; ifa.addr = a; ifa.data_in = d;
        ifb.mem_rd = rd; ifb.mem_wr = wr; ifb.addr = a; ifb.data_in = d;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_err = 0; m_rv = 0; m_wd = 0;
        m_st = 2'b00; m_data = 8'h00; m_dknown = 1; m_rc = 0; m_wc = 0;
    endtask

    // One clock edge of the responder's rules, in priority order.
    task automatic model_edge();
        m_rv = 0; m_wd = 0;
        if (cur_rd && cur_wr) begin
            m_err = 1; m_st = 2'b11;
        end else if (cur_rd) begin
            m_data = mem[cur_a]; m_dknown = mknow[cur_a];
            m_rv = 1; m_st = 2'b01; m_rc++;
        end else if (cur_wr && !m_prev) begin
            mem[cur_a] = cur_d; mknow[cur_a] = 1;
            m_wd = 1; m_st = 2'b10; m_wc++;
        end else begin
            m_st = 2'b00;
        end
        m_prev = cur_wr;
    endtask

    task automatic compare_model();
        chk("m_rstate",   32'(ifa.rstate),   32'(m_st));
        chk("m_rd_valid", 32'(ifa.rd_valid), 32'(m_rv));
        chk("m_wr_done",  32'(ifa.wr_done),  32'(m_wd));
        chk("m_err",      32'(ifa.err),      32'(m_err));
        chk("m_rd_cnt",   32'(ifa.rd_count), 32'(sat(m_rc, 255)));
        chk("m_wr_cnt",   32'(ifa.wr_count), 32'(sat(m_wc, 255)));
        chk("m_rd_cnt4",  32'(ifb.rd_count), 32'(sat(m_rc, 15)));
        chk("m_wr_cnt4",  32'(ifb.wr_count), 32'(sat(m_wc, 15)));
        chk("m_rstate4",  32'(ifb.rstate),   32'(m_st));
        if (m_dknown) begin
            chk("m_data",  32'(ifa.data_out), 32'(m_data));
            chk("m_data4", 32'(ifb.data_out), 32'(m_data));
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        rst = 1'b0;
        model_reset();
        #1;
        compare_model();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    typedef struct {
        bit         rstb;
        bit         rd;
        bit         wr;
        logic [4:0] a;
        logic [7:0] d;
        logic [1:0] st;
        bit         rv;
        bit         wd;
        bit         er;
        logic [7:0] dout;
        int         rc;
        int         wc;
    } vec_t;

    vec_t tbl [22];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; mknow[i] = 0; end

        //            rstb rd wr addr   data   st    rv wd er dout  rc wc
        tbl[0]  = '{1, 0, 1, 5'h03, 8'hA5, 2'd2, 0, 1, 0, 8'h00, 0, 1};
        tbl[1]  = '{0, 0, 1, 5'h03, 8'hA5, 2'd0, 0, 0, 0, 8'h00, 0, 1};
        tbl[2]  = '{0, 0, 1, 5'h03, 8'hA5, 2'd0, 0, 0, 0, 8'h00, 0, 1};
        tbl[3]  = '{0, 0, 0, 5'h03, 8'h00, 2'd0, 0, 0, 0, 8'h00, 0, 1};
        tbl[4]  = '{0, 1, 0, 5'h03, 8'h00, 2'd1, 1, 0, 0, 8'hA5, 1, 1};
        tbl[5]  = '{0, 0, 0, 5'h03, 8'h00, 2'd0, 0, 0, 0, 8'hA5, 1, 1};
        tbl[6]  = '{1, 0, 1, 5'h00, 8'h5C, 2'd2, 0, 1, 0, 8'h00, 0, 1};
        tbl[7]  = '{0, 0, 0, 5'h00, 8'h00, 2'd0, 0, 0, 0, 8'h00, 0, 1};
        tbl[8]  = '{0, 1, 0, 5'h00, 8'h00, 2'd1, 1, 0, 0, 8'h5C, 1, 1};
        tbl[9]  = '{0, 1, 0, 5'h00, 8'h00, 2'd1, 1, 0, 0, 8'h5C, 2, 1};
        tbl[10] = '{0, 0, 0, 5'h00, 8'h00, 2'd0, 0, 0, 0, 8'h5C, 2, 1};
        tbl[11] = '{0, 0, 1, 5'h07, 8'h11, 2'd2, 0, 1, 0, 8'h5C, 2, 2};
        tbl[12] = '{0, 1, 0, 5'h07, 8'h00, 2'd1, 1, 0, 0, 8'h11, 3, 2};
        tbl[13] = '{0, 0, 0, 5'h00, 8'h00, 2'd0, 0, 0, 0, 8'h11, 3, 2};
        tbl[14] = '{0, 0, 1, 5'h02, 8'h33, 2'd2, 0, 1, 0, 8'h11, 3, 3};
        tbl[15] = '{0, 0, 0, 5'h02, 8'h00, 2'd0, 0, 0, 0, 8'h11, 3, 3};
        tbl[16] = '{0, 1, 1, 5'h02, 8'hFF, 2'd3, 0, 0, 1, 8'h11, 3, 3};
        tbl[17] = '{0, 1, 1, 5'h02, 8'hFF, 2'd3, 0, 0, 1, 8'h11, 3, 3};
        tbl[18] = '{0, 0, 0, 5'h02, 8'h00, 2'd0, 0, 0, 1, 8'h11, 3, 3};
        tbl[19] = '{0, 1, 0, 5'h02, 8'h00, 2'd1, 1, 0, 1, 8'h33, 4, 3};
        tbl[20] = '{0, 0, 0, 5'h02, 8'h00, 2'd0, 0, 0, 1, 8'h33, 4, 3};
        tbl[21] = '{1, 0, 0, 5'h00, 8'h00, 2'd0, 0, 0, 0, 8'h00, 0, 0};

        drive(1'b0, 1'b0, 5'd0, 8'd0);
        #2;
        do_reset();

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rstb) do_reset();
            drive(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
            step_cycle();
            chk($sformatf("t%0d_rstate", i),   32'(ifa.rstate),   32'(tbl[i].st));
            chk($sformatf("t%0d_rd_valid", i), 32'(ifa.rd_valid), 32'(tbl[i].rv));
            chk($sformatf("t%0d_wr_done", i),  32'(ifa.wr_done),  32'(tbl[i].wd));
            chk($sformatf("t%0d_err", i),      32'(ifa.err),      32'(tbl[i].er));
            chk($sformatf("t%0d_data", i),     32'(ifa.data_out), 32'(tbl[i].dout));
            chk($sformatf("t%0d_rd_cnt", i),   32'(ifa.rd_count), 32'(tbl[i].rc));
            chk($sformatf("t%0d_wr_cnt", i),   32'(ifa.wr_count), 32'(tbl[i].wc));
        end

        // 20 back-to-back reads: 4-bit counter pins at 15, 8-bit reaches 20
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 5'(i), 8'h00);
            step_cycle();
        end
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        step_cycle();
        chk("sat_rd_cnt4", 32'(ifb.rd_count), 32'h0000000F);
        chk("sat_rd_cnt8", 32'(ifa.rd_count), 32'd20);

        // reset lands while mem_wr is high, before its commit edge
        drive(1'b0, 1'b1, 5'd10, 8'h77);
        step_cycle();
        drive(1'b0, 1'b0, 5'd0, 8'h00);
        step_cycle();
        drive(1'b0, 1'b1, 5'd10, 8'h3C);
        #3 rst = 1'b0;
        model_reset();
        #1;
        chk("rstmid_rstate", 32'(ifa.rstate),   32'd0);
        chk("rstmid_wr_cnt", 32'(ifa.wr_count), 32'd0);
        chk("rstmid_rd_cnt", 32'(ifa.rd_count), 32'd0);
        chk("rstmid_data",   32'(ifa.data_out), 32'd0);
        @(posedge clk);
        #1;
        compare_model();
        #2 rst = 1'b1;
        drive(1'b0, 1'b1, 5'd9, 8'h4D);
        step_cycle();
        chk("rstrel_wr_done", 32'(ifa.wr_done),  32'd1);
        chk("rstrel_wr_cnt",  32'(ifa.wr_count), 32'd1);
        step_cycle();
        chk("rstrel_held_cnt", 32'(ifa.wr_count), 32'd1);
        drive(1'b1, 1'b0, 5'd10, 8'h00);
        step_cycle();
        chk("rstrel_ram10", 32'(ifa.data_out), 32'h77);
        drive(1'b1, 1'b0, 5'd9, 8'h00);
        step_cycle();
        chk("rstrel_ram9", 32'(ifa.data_out), 32'h4D);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: drive(1'b1, 1'b0, 5'($urandom), 8'($urandom));
                4, 5, 6:    drive(1'b0, 1'b1, 5'($urandom), 8'($urandom));
                7:          drive(1'b1, 1'b1, 5'($urandom), 8'($urandom));
                default:    drive(1'b0, 1'b0, 5'($urandom), 8'($urandom));
            endcase
            step_cycle();
            if (i == 200) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
